adc_sampler: RTL and testbench

Free-running SPI master for the dual-channel 12-bit MCP3202 ADC that produces the `p1data`/`p2data` player voltage codes consumed by the screen-selection logic (single-player and tug-of-war modes). It alternates conversions between CH0 (player 1) and CH1 (player 2), box-car averages 2^AVG_LOG2 samples per channel, and presents both averaged codes as registered outputs with a one-cycle update strobe.

---
 rtl/adc_sampler.sv | 217 +++++++++++++++++++++
 tb/tb_adc_sampler.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sampler.sv
// adc_sampler
//   Free-running SPI master for a dual-channel 12-bit MCP3202 ADC.
//   Conversions alternate CH0 (player 1) and CH1 (player 2). Each channel is
//   box-car averaged over 2^AVG_LOG2 samples. Both averaged codes are
//   registered outputs with a one-cycle update strobe.
//
//   Ports:
//     clk          - system clock
//     reset        - synchronous, active-high reset
//     miso         - ADC DOUT
//     sck          - SPI clock, mode 0, idles low
//     cs_n         - ADC chip select, active low
//     mosi         - ADC DIN
//     p1data       - averaged CH0 code
//     p2data       - averaged CH1 code
//     sample_valid - one-cycle pulse when p1data/p2data update
//
//   Frame timing, in clk cycles:
//     CS_HIGH  2*CLKDIV  (cs_n high)
//     SHIFT    34*CLKDIV (cs_n low; 17 SCK periods of CLKDIV low + CLKDIV high)
//     CAPTURE  1         (cs_n high; accumulate and, at batch end, publish)
//   Frame period is therefore 36*CLKDIV + 1 cycles.
//
//   The FSM state is held in state_q so that checkers can bind to it.
module adc_sampler #(
    parameter int CLKDIV   = 32,
    parameter int AVG_LOG2 = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        miso,
    output logic        sck,
    output logic        cs_n,
    output logic        mosi,
    output logic [11:0] p1data,
    output logic [11:0] p2data,
    output logic        sample_valid
);

    localparam int CNT_W = $clog2(2 * CLKDIV) + 1;
    localparam int ACC_W = 12 + AVG_LOG2;
    localparam int FRM_W = AVG_LOG2 + 1;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKDIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(2 * CLKDIV - 1);
    // A batch is 2*2^AVG_LOG2 frames; the last one is always a CH1 frame.
    localparam logic [FRM_W-1:0] FRM_LAST  = FRM_W'((2 << AVG_LOG2) - 1);

    typedef enum logic [1:0] {
        CS_HIGH = 2'd0,
        SHIFT   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [4:0]         bit_q, bit_d;      // current SCK bit k, 1..17
    logic               sck_q, sck_d;
    logic               cs_n_q, cs_n_d;
    logic               mosi_q, mosi_d;
    logic               chan_q, chan_d;    // 0 = CH0, 1 = CH1
    logic [11:0]        shift_q, shift_d;
    logic [ACC_W-1:0]   acc0_q, acc0_d;
    logic [ACC_W-1:0]   acc1_q, acc1_d;
    logic [FRM_W-1:0]   frm_q, frm_d;
    logic [11:0]        p1_q, p1_d;
    logic [11:0]        p2_q, p2_d;
    logic               valid_q, valid_d;

    // acc1 including the code of the frame being captured; p2data at batch
    // end must see this frame's sample.
    logic [ACC_W-1:0]   acc1_sum;

    // Command bits on DIN: start, SGL, ODD (channel), MSBF, then zeros.
    function automatic logic mosi_for(input logic [4:0] k, input logic ch);
        logic b;
        b = 1'b0;
        case (k)
            5'd1:    b = 1'b1;
            5'd2:    b = 1'b1;
            5'd3:    b = ch;
            5'd4:    b = 1'b1;
            default: b = 1'b0;
        endcase
        return b;
    endfunction

    assign acc1_sum = acc1_q + ACC_W'(shift_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sck_d   = sck_q;
        cs_n_d  = cs_n_q;
        mosi_d  = mosi_q;
        chan_d  = chan_q;
        shift_d = shift_q;
        acc0_d  = acc0_q;
        acc1_d  = acc1_q;
        frm_d   = frm_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        valid_d = 1'b0;

        case (state_q)
            CS_HIGH: begin
                cs_n_d = 1'b1;
                sck_d  = 1'b0;
                if (cnt_q == GAP_LAST) begin
                    // cs_n falls together with the first command bit.
                    state_d = SHIFT;
                    cnt_d   = '0;
                    cs_n_d  = 1'b0;
                    bit_d   = 5'd1;
                    mosi_d  = mosi_for(5'd1, chan_q);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            SHIFT: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!sck_q) begin
                        // Rising SCK edge: data bits B11..B0 arrive on k=6..17.
                        sck_d = 1'b1;
                        if (bit_q >= 5'd6) begin
                            shift_d = {shift_q[10:0], miso};
                        end
                    end else begin
                        // Falling SCK edge: end of bit k, DIN moves to k+1.
                        sck_d = 1'b0;
                        if (bit_q == 5'd17) begin
                            state_d = CAPTURE;
                            cs_n_d  = 1'b1;
                            mosi_d  = 1'b0;
                        end else begin
                            bit_d  = bit_q + 5'd1;
                            mosi_d = mosi_for(bit_q + 5'd1, chan_q);
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            CAPTURE: begin
                state_d = CS_HIGH;
                cnt_d   = '0;
                chan_d  = ~chan_q;
                if (chan_q) begin
                    acc1_d = acc1_sum;
                end else begin
                    acc0_d = acc0_q + ACC_W'(shift_q);
                end
                if (frm_q == FRM_LAST) begin
                    p1_d    = acc0_q[ACC_W-1:AVG_LOG2];
                    p2_d    = acc1_sum[ACC_W-1:AVG_LOG2];
                    valid_d = 1'b1;
                    acc0_d  = '0;
                    acc1_d  = '0;
                    frm_d   = '0;
                end else begin
                    frm_d = frm_q + FRM_W'(1);
                end
            end

            default: begin
                state_d = CS_HIGH;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CS_HIGH;
            cnt_q   <= '0;
            bit_q   <= '0;
            sck_q   <= 1'b0;
            cs_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
            chan_q  <= 1'b0;
            shift_q <= '0;
            acc0_q  <= '0;
            acc1_q  <= '0;
            frm_q   <= '0;
            p1_q    <= '0;
            p2_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sck_q   <= sck_d;
            cs_n_q  <= cs_n_d;
            mosi_q  <= mosi_d;
            chan_q  <= chan_d;
            shift_q <= shift_d;
            acc0_q  <= acc0_d;
            acc1_q  <= acc1_d;
            frm_q   <= frm_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            valid_q <= valid_d;
        end
    end

    assign sck          = sck_q;
    assign cs_n         = cs_n_q;
    assign mosi         = mosi_q;
    assign p1data       = p1_q;
    assign p2data       = p2_q;
    assign sample_valid = valid_q;

endmodule

// File: tb/tb_adc_sampler.sv
// tb_adc_sampler
//   Three adc_sampler instances run side by side, each with its own MCP3202
//   model:
//     inst 0: CLKDIV=2, AVG_LOG2=0  (frame format, pass-through, mid-frame reset)
//     inst 1: CLKDIV=2, AVG_LOG2=2  (averaging)
//     inst 2: CLKDIV=1, AVG_LOG2=1  (averaging with truncation, pulse spacing)
//   Expected {p1data, p2data} pairs are pushed into exp_q when the ADC code
//   tables are loaded; a monitor per instance pops and compares on every
//   sample_valid pulse. Outputs are sampled on the falling clk edge.
module tb_adc_sampler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rst;
    wire  [2:0]  sck_w, cs_n_w, mosi_w, sv_w, miso_w, ch_w;
    wire  [11:0] p1_w [3];
    wire  [11:0] p2_w [3];
    wire  [4:0]  k_w [3];

    logic [11:0] tab0 [3][4];
    logic [11:0] tab1 [3][4];
    logic [23:0] exp_q [3][$];
    logic [16:0] fbits_q [$];
    int          fk_q [$];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, got, got, want, want);
        end
    endtask

    for (genvar i = 0; i < 3; i++) begin : g
        localparam int CDIV    = (i == 2) ? 1 : 2;
        localparam int ALOG    = (i == 0) ? 0 : ((i == 1) ? 2 : 1);
        localparam int SPACING = 2 * (1 << ALOG) * (36 * CDIV + 1);

        logic        miso_r = 1'b0;
        int          k      = 0;
        logic        ch     = 1'b0;
        int          n0     = 0;
        int          n1     = 0;
        logic [11:0] code   = '0;
        logic [16:0] bits   = '0;

        assign miso_w[i] = miso_r;
        assign k_w[i]    = k[4:0];
        assign ch_w[i]   = ch;

        adc_sampler #(.CLKDIV(CDIV), .AVG_LOG2(ALOG)) dut (
            .clk          (clk),
            .reset        (rst[i]),
            .miso         (miso_w[i]),
            .sck          (sck_w[i]),
            .cs_n         (cs_n_w[i]),
            .mosi         (mosi_w[i]),
            .p1data       (p1_w[i]),
            .p2data       (p2_w[i]),
            .sample_valid (sv_w[i])
        );

        // ADC model: counts SCK rising edges while selected, decodes ODD on
        // k=3 and picks the code for that channel, logs DIN for inst 0.
        always @(posedge sck_w[i] or posedge cs_n_w[i]) begin
            if (cs_n_w[i]) begin
                if (i == 0 && k > 0) begin
                    fbits_q.push_back(bits);
                    fk_q.push_back(k);
                end
                k    = 0;
                bits = '0;
            end else begin
                k = k + 1;
                if (k <= 17) bits[k-1] = mosi_w[i];
                if (k == 3) ch = mosi_w[i];
                if (k == 4) begin
                    if (ch) begin
                        code = tab1[i][n1 % 4];
                        n1++;
                    end else begin
                        code = tab0[i][n0 % 4];
                        n0++;
                    end
                end
            end
        end

        // DOUT changes on SCK falling edges: B11 follows the null bit (k=5).
        always @(negedge sck_w[i]) begin
            if (!cs_n_w[i] && k >= 5 && k <= 16) miso_r = code[16-k];
        end

        // Monitor / scoreboard consumer.
        logic        prev_sv  = 1'b0;
        logic [11:0] prev_p1  = '0;
        logic [11:0] prev_p2  = '0;
        logic [11:0] last_p1  = '0;
        logic [11:0] last_p2  = '0;
        int          last_cyc = -1;
        logic [23:0] e;

        always @(negedge clk) begin
            if (rst[i]) begin
                last_p1  = '0;
                last_p2  = '0;
                last_cyc = -1;
            end else begin
                if (prev_sv) check($sformatf("pulse_width[%0d]", i), sv_w[i], 0);
                if (sv_w[i]) begin
                    check($sformatf("hold_p1[%0d]", i), prev_p1, last_p1);
                    check($sformatf("hold_p2[%0d]", i), prev_p2, last_p2);
                    check($sformatf("pulse_expected[%0d]", i), int'(exp_q[i].size() > 0), 1);
                    if (exp_q[i].size() > 0) begin
                        e = exp_q[i].pop_front();
                        check($sformatf("p1data[%0d]", i), p1_w[i], e[23:12]);
                        check($sformatf("p2data[%0d]", i), p2_w[i], e[11:0]);
                        last_p1 = e[23:12];
                        last_p2 = e[11:0];
                    end
                    if (last_cyc >= 0) check($sformatf("pulse_spacing[%0d]", i), cyc - last_cyc, SPACING);
                    last_cyc = cyc;
                end
            end
            prev_sv = sv_w[i];
            prev_p1 = p1_w[i];
            prev_p2 = p2_w[i];
        end
    end

    initial begin
        int n;
        int lo;
        int hi;

        for (int j = 0; j < 4; j++) begin
            tab0[0][j] = 12'hABC;
            tab1[0][j] = 12'h123;
            tab0[1][j] = 12'(100 + j);
            tab1[1][j] = 12'd4095;
        end
        tab0[2][0] = 12'd10;   tab0[2][1] = 12'd20;
        tab0[2][2] = 12'd30;   tab0[2][3] = 12'd40;
        tab1[2][0] = 12'd7;    tab1[2][1] = 12'd8;
        tab1[2][2] = 12'd1000; tab1[2][3] = 12'd1001;

        exp_q[0].push_back({12'hABC, 12'h123});
        // (100+101+102+103)>>2 = 101, (4*4095)>>2 = 4095
        exp_q[1].push_back({12'd101, 12'd4095});
        exp_q[1].push_back({12'd101, 12'd4095});
        // (10+20)>>1=15, (7+8)>>1=7 ; (30+40)>>1=35, (1000+1001)>>1=1000
        for (int j = 0; j < 3; j++) begin
            exp_q[2].push_back({12'd15, 12'd7});
            exp_q[2].push_back({12'd35, 12'd1000});
        end

        rst = 3'b111;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int j = 0; j < 3; j++) begin
            check($sformatf("rst_cs_n[%0d]", j), cs_n_w[j], 1);
            check($sformatf("rst_sck[%0d]", j), sck_w[j], 0);
            check($sformatf("rst_mosi[%0d]", j), mosi_w[j], 0);
            check($sformatf("rst_p1[%0d]", j), p1_w[j], 0);
            check($sformatf("rst_p2[%0d]", j), p2_w[j], 0);
            check($sformatf("rst_valid[%0d]", j), sv_w[j], 0);
        end
        rst = 3'b000;

        // First cs_n fall: 2*CLKDIV edges after release.
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (!cs_n_w[0]) break;
        end
        check("first_cs_fall_cycles", n, 4);

        lo = 0;
        do begin
            lo++;
            @(negedge clk);
        end while (!cs_n_w[0] && lo < 200);
        check("cs_low_cycles", lo, 68);
        hi = 0;
        do begin
            hi++;
            @(negedge clk);
        end while (cs_n_w[0] && hi < 200);
        check("cs_high_cycles", hi, 5);

        n = 0;
        while (fk_q.size() < 2 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("frames_logged", int'(fk_q.size() >= 2), 1);
        if (fk_q.size() >= 2) begin
            check("frame0_sck_edges", fk_q[0], 17);
            check("frame0_mosi", fbits_q[0], 17'h0000B);
            check("frame1_sck_edges", fk_q[1], 17);
            check("frame1_mosi", fbits_q[1], 17'h0000F);
        end

        n = 0;
        while (exp_q[0].size() > 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("inst0_first_batch_timeout", int'(exp_q[0].size()), 0);

        // Mid-frame reset at SCK rising edge 10 of a CH1 frame.
        n = 0;
        while (!(k_w[0] == 5'd10 && ch_w[0]) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("ch1_bit10_found", int'(n < 1000), 1);
        for (int j = 0; j < 4; j++) begin
            tab0[0][j] = 12'h555;
            tab1[0][j] = 12'h0F0;
        end
        exp_q[0].push_back({12'h555, 12'h0F0});
        rst[0] = 1'b1;
        @(negedge clk);
        check("midrst_cs_n", cs_n_w[0], 1);
        check("midrst_sck", sck_w[0], 0);
        check("midrst_p1", p1_w[0], 0);
        check("midrst_p2", p2_w[0], 0);
        rst[0] = 1'b0;

        n = 0;
        while (cs_n_w[0] && n < 100) begin
            @(negedge clk);
            n++;
        end
        while (k_w[0] < 5'd3 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("post_reset_odd", ch_w[0], 0);

        n = 0;
        while (exp_q[0].size() > 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("inst0_post_reset_batch_timeout", int'(exp_q[0].size()), 0);
        rst[0] = 1'b1;

        // Park each remaining instance in reset once its expectations drain.
        n = 0;
        while ((exp_q[1].size() > 0 || exp_q[2].size() > 0) && n < 3000) begin
            @(negedge clk);
            n++;
            if (exp_q[1].size() == 0) rst[1] = 1'b1;
            if (exp_q[2].size() == 0) rst[2] = 1'b1;
        end
        rst = 3'b111;
        check("inst1_drained", int'(exp_q[1].size()), 0);
        check("inst2_drained", int'(exp_q[2].size()), 0);

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
